instr_encoder: RTL and testbench

- Inverse of the datapath's opcode decoder. Accepts decoded instruction fields (class, registers, funct, immediate) over a valid/ready handshake.
- Packs them into 32-bit RISC-V instruction words and buffers them in a 2-entry FIFO.
- Emits each word with a sequential word address over a second valid/ready handshake.
- Sits between the testbench/boot loader and the instruction-memory write port. Used to generate programs for the single-cycle and pipelined cores.

---
 rtl/instr_encoder.sv | 131 +++++++++++++
 tb/tb_instr_encoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 32-bit RISC-V words, buffers them in a
// 2-entry FIFO and emits each with a sequential word address.
// Optional macro IMM_RANGE_CHECK_EN: drop and flag bundles whose immediate does not fit.
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [20:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [1:0]        count
);

  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

  localparam logic [2:0] CLS_R     = 3'd0;
  localparam logic [2:0] CLS_I     = 3'd1;
  localparam logic [2:0] CLS_LOAD  = 3'd2;
  localparam logic [2:0] CLS_STORE = 3'd3;
  localparam logic [2:0] CLS_BEQ   = 3'd4;
  localparam logic [2:0] CLS_JAL   = 3'd5;

  logic [31:0]       word;
  logic              cls_ok;
  logic              imm_ok;
  logic              legal;
  logic              accept;
  logic              push;
  logic              pop;
  logic [31:0]       mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] addr;
  logic              err_q;

  always_comb begin
    word   = '0;
    cls_ok = 1'b1;
    case (in_class)
      CLS_R:     word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      CLS_I:     word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      CLS_LOAD:  word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      CLS_STORE: word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      CLS_BEQ:   word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                         in_imm[4:1], in_imm[11], 7'b1100011};
      CLS_JAL:   word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                         in_rd, 7'b1101111};
      default:   cls_ok = 1'b0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // An immediate fits when every bit above its signed field matches the field's sign bit.
  always_comb begin
    imm_ok = 1'b1;
    case (in_class)
      CLS_I, CLS_LOAD, CLS_STORE:
        imm_ok = (in_imm[20:11] == '0) || (in_imm[20:11] == '1);
      CLS_BEQ:
        imm_ok = ((in_imm[20:12] == '0) || (in_imm[20:12] == '1)) && !in_imm[0];
      CLS_JAL:
        imm_ok = !in_imm[0];
      default:
        imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  assign legal     = cls_ok & imm_ok;
  assign in_ready  = (cnt != 2'd2) & ~flush;
  assign out_valid = (cnt != 2'd0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & legal;
  assign pop       = out_valid & out_ready & ~flush;
  assign out_instr = mem[rd_ptr];
  assign out_addr  = addr;
  assign err       = err_q;
  assign count     = cnt;

  // Illegal bundles complete the handshake but never reach the FIFO.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      addr   <= START;
      err_q  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      addr   <= START;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        addr   <= addr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      if (accept && !legal) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder: a queue-based reference model
// predicts occupancy, words, addresses and err every cycle.
module tb_instr_encoder;

  localparam int AW = 2;
  localparam int START = 0;

  logic          clk;
  logic          arst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_class;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [20:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err;
  logic [1:0]    count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  int  m_addr;
  bit  m_err;

  instr_encoder #(.ADDR_W(AW), .START_ADDR(START)) dut (
    .clk(clk), .arst_n(arst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic longint fld(input longint v, input int lo, input int n);
    return (v >>> lo) & ((longint'(1) << n) - 1);
  endfunction

  // Reference packing built from the ISA bit positions with shifts and masks.
  function automatic logic [31:0] refEncode(input int cls, input int rd, input int rs1,
                                            input int rs2, input int f3, input int f7,
                                            input longint imm);
    longint w;
    w = 0;
    case (cls)
      0: w = 51 + (rd << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + (f7 << 25);
      1: w = 19 + (rd << 7) + (f3 << 12) + (rs1 << 15) + (fld(imm, 0, 12) << 20);
      2: w = 3  + (rd << 7) + (f3 << 12) + (rs1 << 15) + (fld(imm, 0, 12) << 20);
      3: w = 35 + (fld(imm, 0, 5) << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20)
             + (fld(imm, 5, 7) << 25);
      4: w = 99 + (fld(imm, 11, 1) << 7) + (fld(imm, 1, 4) << 8) + (rs1 << 15)
             + (rs2 << 20) + (fld(imm, 5, 6) << 25) + (fld(imm, 12, 1) << 31);
      5: w = 111 + (rd << 7) + (fld(imm, 12, 8) << 12) + (fld(imm, 11, 1) << 20)
             + (fld(imm, 1, 10) << 21) + (fld(imm, 20, 1) << 31);
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  function automatic bit refLegal(input int cls, input longint imm);
    if (cls > 5) return 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    if (cls >= 1 && cls <= 3) return (imm >= -2048 && imm <= 2047);
    if (cls == 4) return (imm >= -4096 && imm <= 4094 && (imm % 2) == 0);
    if (cls == 5) return ((imm % 2) == 0);
`endif
    return 1'b1;
  endfunction

  task automatic compareState();
    checkOutput("count", 32'(count), 32'(exp_q.size()));
    checkOutput("in_ready", 32'(in_ready), 32'(exp_q.size() < 2 && !flush));
    checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    checkOutput("err", 32'(err), 32'(m_err));
    if (exp_q.size() > 0) begin
      checkOutput("out_instr", out_instr, exp_q[0]);
      checkOutput("out_addr", 32'(out_addr), 32'(m_addr));
    end
  endtask

  task automatic applyStimulus(input bit v, input int cls, input int rd, input int rs1,
                               input int rs2, input int f3, input int f7, input int imm,
                               input bit ordy, input bit fl, output bit acc);
    bit pop;
    longint simm;
    in_valid  = v;
    in_class  = 3'(cls);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_funct3 = 3'(f3);
    in_funct7 = 7'(f7);
    in_imm    = 21'(imm);
    out_ready = ordy;
    flush     = fl;
    simm = longint'($signed(in_imm));
    acc = v && exp_q.size() < 2 && !fl;
    pop = exp_q.size() > 0 && ordy && !fl;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      m_addr = START;
      m_err  = 1'b0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        m_addr = (m_addr + 1) % (1 << AW);
      end
      if (acc) begin
        if (refLegal(cls, simm)) exp_q.push_back(refEncode(cls, rd, rs1, rs2, f3, f7, simm));
        else m_err = 1'b1;
      end
    end
    @(negedge clk);
    compareState();
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, ordy, 1'b0, acc);
  endtask

  initial begin
    bit acc;
    int tries;
    arst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    exp_q.delete(); m_addr = START; m_err = 1'b0;
    #3;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_out_addr", 32'(out_addr), 32'(START));
    checkOutput("rst_out_instr", out_instr, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // R-type add x3,x1,x2 held at the output
    applyStimulus(1, 0, 3, 1, 2, 0, 0, 0, 0, 0, acc);
    checkOutput("r_word", out_instr, 32'h002081B3);
    checkOutput("r_addr", 32'(out_addr), 32'd0);
    idle(1);

    // addi / lw / sw streamed from a fresh address
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, acc);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 5, 1, 0, acc);
    checkOutput("addi_word", out_instr, 32'h00500093);
    applyStimulus(1, 2, 5, 1, 0, 2, 0, 4, 1, 0, acc);
    checkOutput("lw_word", out_instr, 32'h0040A283);
    checkOutput("lw_addr", 32'(out_addr), 32'd1);
    applyStimulus(1, 3, 0, 1, 2, 2, 0, 12, 1, 0, acc);
    checkOutput("sw_word", out_instr, 32'h0020A623);
    checkOutput("sw_addr", 32'(out_addr), 32'd2);
    idle(1);

    // BEQ then JAL, output stalled so both sit in the FIFO
    applyStimulus(1, 4, 0, 1, 2, 5, 0, 8, 0, 0, acc);
    checkOutput("beq_word", out_instr, 32'h00208463);
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 16, 0, 0, acc);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    // Third bundle stalls while full, then goes in once the output drains
    applyStimulus(1, 1, 7, 7, 0, 0, 0, -3, 0, 0, acc);
    checkOutput("stall_word", out_instr, 32'h00208463);
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 6) begin
      applyStimulus(1, 1, 7, 7, 0, 0, 0, -3, 1, 0, acc);
      tries++;
    end
    if (!acc) checkOutput("retry_timeout", 32'd0, 32'd1);
    idle(1); idle(1); idle(1);

    // Illegal class sets err, flush clears it
    applyStimulus(1, 6, 1, 1, 1, 0, 0, 0, 1, 0, acc);
    checkOutput("illegal_err", 32'(err), 32'd1);
    applyStimulus(1, 7, 1, 1, 1, 0, 0, 0, 1, 0, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, acc);
    checkOutput("flush_err", 32'(err), 32'd0);
`ifdef IMM_RANGE_CHECK_EN
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 2048, 1, 0, acc);
    checkOutput("range_err", 32'(err), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, acc);
`endif

    // Address wrap over five back-to-back words
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, i, 0, 0, 0, 0, i, 1, 0, acc);
    idle(1); idle(1);

    // Randomized traffic with a mid-stream asynchronous reset
    for (int i = 0; i < 800; i++) begin
      int imm;
      if ($urandom_range(0, 1) == 0) imm = int'($urandom_range(0, 8191)) - 4096;
      else imm = int'($urandom_range(0, 2097151)) - 1048576;
      applyStimulus($urandom_range(0, 9) < 7, int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 127)), imm,
                    $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, acc);
      if (i == 400) begin
        arst_n = 1'b0;
        #1;
        exp_q.delete(); m_addr = START; m_err = 1'b0;
        checkOutput("midrst_count", 32'(count), 32'd0);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        #1;
        arst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
